// File: rtl/game_pkg.sv
// Shared game definitions: status encodings, move bit indices and small helpers.
package game_pkg;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } game_status_e;

  localparam int NUM_MOVES = 4;
  localparam int MOVE_0    = 0;
  localparam int MOVE_1    = 1;
  localparam int MOVE_2    = 2;
  localparam int MOVE_3    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01,
    ST_GAP  = 2'b10
  } enc_state_e;

  // Isolate the lowest set bit, so move 0 wins over move 3.
  function automatic logic [NUM_MOVES-1:0] lowest_onehot(input logic [NUM_MOVES-1:0] req);
    return req & (~req + {{(NUM_MOVES-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: two-flop synchronizer followed by a hold-time debouncer.
// press_o pulses for one cycle when the debounced level goes 0->1.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize, then accept a new level only after it has disagreed for the full hold time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          press_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/move_encoder.sv
// Turns four debounced buttons into one-hot move strobes, one move per slot,
// each slot followed by a fixed number of idle cycles.
module move_encoder
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic [1:0] game_status,
  output logic [3:0] act,
  output logic       active
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [NUM_MOVES-1:0] level;
  logic [NUM_MOVES-1:0] press;

  for (genvar i = 0; i < NUM_MOVES; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (btn_raw[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  enc_state_e           state_q;
  logic [NUM_MOVES-1:0] pending_q;
  logic [NUM_MOVES-1:0] act_q;
  logic                 active_q;
  logic [GAP_W-1:0]     gap_q;

  logic [NUM_MOVES-1:0] req_d;
  logic [NUM_MOVES-1:0] pick_d;
  logic                 winned;
  logic                 gap_done;
  logic                 emit_now;

  // A press counts only while its debounced level is high; the FSM also sees
  // presses arriving this very cycle so the first move is not delayed a cycle.
  always_comb begin
    req_d    = pending_q | (press & level);
    pick_d   = lowest_onehot(req_d);
    winned   = (game_status == WINNED);
    gap_done = (gap_q == GAP_LAST);
    emit_now = (req_d != '0) && !winned &&
               ((state_q == ST_IDLE) || ((state_q == ST_GAP) && gap_done));
  end

  // Slot sequencer: IDLE waits for work, EMIT shows one move, GAP enforces spacing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      act_q     <= '0;
      active_q  <= 1'b0;
      gap_q     <= '0;
    end else begin
      act_q     <= '0;
      active_q  <= 1'b0;
      pending_q <= winned ? '0 : req_d;
      case (state_q)
        ST_IDLE: ;
        ST_EMIT: begin
          state_q <= ST_GAP;
          gap_q   <= '0;
        end
        ST_GAP: begin
          if (gap_done) state_q <= ST_IDLE;
          else          gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (emit_now) begin
        state_q   <= ST_EMIT;
        act_q     <= pick_d;
        active_q  <= 1'b1;
        pending_q <= req_d & ~pick_d;
      end
    end
  end

  assign act    = act_q;
  assign active = active_q;

endmodule

// File: tb/tb_move_encoder.sv
// Bench for move_encoder with DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
module tb_move_encoder;

  localparam int D = 4;
  localparam int G = 2;
  localparam logic [1:0] S_CHOSE = 2'b00;
  localparam logic [1:0] S_GAME  = 2'b01;
  localparam logic [1:0] S_INIT  = 2'b10;
  localparam logic [1:0] S_WIN   = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [1:0] game_status = S_GAME;
  logic [3:0] act;
  logic       active;

  always #5 clk = ~clk;

  move_encoder #(
    .DEBOUNCE_CYCLES(D),
    .GAP_CYCLES     (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .game_status(game_status),
    .act        (act),
    .active     (active)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: per-button hold timers and a slot calendar (next edge a move may appear).
  bit [3:0] m_s1, m_s2, m_lvl, m_press, m_pend, m_act;
  int       m_run [4];
  int       m_next_ok;

  int       pulse_cyc [$];
  bit [3:0] pulse_act [$];

  task automatic model_edge();
    bit [3:0] req;
    bit [3:0] pick;
    m_act = 4'b0000;
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0; m_pend = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_next_ok = cyc + 1;
    end else begin
      req = m_pend | m_press;
      if (game_status == S_WIN) begin
        m_pend = 4'b0000;
      end else if (req != 4'b0000 && cyc >= m_next_ok) begin
        pick = 4'b0000;
        for (int i = 3; i >= 0; i--) if (req[i]) pick = 4'(1 << i);
        m_act     = pick;
        m_pend    = req & ~pick;
        m_next_ok = cyc + 1 + G;
      end else begin
        m_pend = req;
      end
      for (int i = 0; i < 4; i++) begin
        m_press[i] = 1'b0;
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_lvl[i]   = m_s2[i];
            m_press[i] = m_s2[i];
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  endtask

  task automatic step(input logic [3:0] b, input logic [1:0] st, input logic rst);
    btn_raw     = b;
    game_status = st;
    reset       = rst;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    n_cmp++;
    if (act !== m_act || active !== (m_act != 4'b0000)) begin
      n_bad++;
      $display("FAIL cycle_check cyc=%0d act=%b active=%b required act=%b active=%b",
               cyc, act, active, m_act, (m_act != 4'b0000));
    end
    if (active === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_act.push_back(act);
    end
  endtask

  task automatic steps(input int n, input logic [3:0] b, input logic [1:0] st);
    for (int k = 0; k < n; k++) step(b, st, 1'b1);
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_act.delete();
  endtask

  task automatic expect_pulses(input string name, input int n);
    n_cmp++;
    if (pulse_act.size() != n) begin
      n_bad++;
      $display("FAIL %s pulse_count got=%0d required=%0d", name, pulse_act.size(), n);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) step(4'b0000, S_GAME, 1'b0);
    n_cmp++;
    if (act !== 4'b0000 || active !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs act=%b active=%b required act=0000 active=0", act, active);
    end
    steps(4, 4'b0000, S_GAME);
  endtask

  task automatic test_single();
    int base;
    clear_log();
    base = cyc;
    steps(10, 4'b0001, S_GAME);
    steps(8, 4'b0000, S_GAME);
    expect_pulses("single", 1);
    if (pulse_act.size() == 1) begin
      n_cmp++;
      if (pulse_act[0] !== 4'b0001 || pulse_cyc[0] - base != 2 + D + 1) begin
        n_bad++;
        $display("FAIL single_timing act=%b edge=%0d required act=0001 edge=%0d",
                 pulse_act[0], pulse_cyc[0] - base, 2 + D + 1);
      end
    end
  endtask

  task automatic test_bounce();
    clear_log();
    steps(3, 4'b0100, S_GAME);
    steps(8, 4'b0000, S_GAME);
    expect_pulses("bounce_short", 0);
    clear_log();
    steps(8, 4'b0100, S_GAME);
    steps(8, 4'b0000, S_GAME);
    expect_pulses("bounce_long", 1);
    if (pulse_act.size() == 1) begin
      n_cmp++;
      if (pulse_act[0] !== 4'b0100) begin
        n_bad++;
        $display("FAIL bounce_act got=%b required=0100", pulse_act[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    clear_log();
    steps(10, 4'b1010, S_GAME);
    steps(10, 4'b0000, S_GAME);
    expect_pulses("simul", 2);
    if (pulse_act.size() == 2) begin
      n_cmp++;
      if (pulse_act[0] !== 4'b0010 || pulse_act[1] !== 4'b1000 ||
          pulse_cyc[1] - pulse_cyc[0] != 1 + G) begin
        n_bad++;
        $display("FAIL simul_order got=%b,%b spacing=%0d required=0010,1000 spacing=%0d",
                 pulse_act[0], pulse_act[1], pulse_cyc[1] - pulse_cyc[0], 1 + G);
      end
    end
  endtask

  task automatic test_winned();
    clear_log();
    steps(12, 4'b0010, S_WIN);
    expect_pulses("winned_held", 0);
    steps(10, 4'b0010, S_INIT);
    expect_pulses("winned_exit_held", 0);
    steps(8, 4'b0000, S_INIT);
    steps(8, 4'b0010, S_INIT);
    steps(8, 4'b0000, S_INIT);
    expect_pulses("winned_repress", 1);
    if (pulse_act.size() == 1) begin
      n_cmp++;
      if (pulse_act[0] !== 4'b0010) begin
        n_bad++;
        $display("FAIL winned_repress_act got=%b required=0010", pulse_act[0]);
      end
    end
  endtask

  task automatic test_reset_in_emit();
    bit seen;
    seen = 1'b0;
    clear_log();
    for (int k = 0; k < 20 && !seen; k++) begin
      step(4'b0100, S_GAME, 1'b1);
      seen = (active === 1'b1);
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL reset_emit_timeout no pulse within 20 cycles, required one");
    end
    step(4'b0000, S_GAME, 1'b0);
    n_cmp++;
    if (act !== 4'b0000 || active !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_emit_clear act=%b active=%b required act=0000 active=0", act, active);
    end
    clear_log();
    steps(15, 4'b0000, S_GAME);
    expect_pulses("reset_emit_noreplay", 0);
  endtask

  task automatic test_gap_press();
    clear_log();
    step(4'b0010, S_GAME, 1'b1);
    steps(9, 4'b0011, S_GAME);
    steps(10, 4'b0000, S_GAME);
    expect_pulses("gap_press", 2);
    if (pulse_act.size() == 2) begin
      n_cmp++;
      if (pulse_act[0] !== 4'b0010 || pulse_act[1] !== 4'b0001) begin
        n_bad++;
        $display("FAIL gap_press_order got=%b,%b required=0010,0001", pulse_act[0], pulse_act[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic [1:0] st;
    int         hold [4];
    b  = 4'b0000;
    st = S_GAME;
    for (int i = 0; i < 4; i++) hold[i] = 1;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          b[i]    = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 12));
        end
      end
      if ($urandom_range(0, 39) == 0) st = 2'($urandom_range(0, 3));
      step(b, st, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
    end
    steps(12, 4'b0000, S_CHOSE);
  endtask

  initial begin
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0; m_pend = 0; m_act = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_next_ok = 0;
    test_reset();
    test_single();
    test_bounce();
    test_simultaneous();
    test_winned();
    test_reset_in_emit();
    test_gap_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
